nonce_block_feeder: RTL and testbench

- Upstream stage of sha256_wrapper.
- Accepts one mining job: header midstate, the 12-byte header tail (merkle tail, time, bits) and a nonce range.
- Iterates the nonce range and, for each nonce, builds the padded 512-bit second block (block2).
- Presents midstate and block2 to the hash core over a valid/ready handshake. Stops on range exhaustion, a found-hit from downstream, or abort.

---
 rtl/miner_pkg.sv | 37 +++
 rtl/nonce_block_feeder_if.sv | 34 +++
 rtl/nonce_block_feeder_block2_pack.sv | 25 ++
 rtl/nonce_block_feeder.sv | 134 +++++++++++++
 tb/tb_nonce_block_feeder.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/miner_pkg.sv
// Shared types and block2 layout constants for the nonce feeder slice.
package miner_pkg;

  localparam int unsigned MIDSTATE_BITS = 256;
  localparam int unsigned TAIL_BITS     = 96;
  localparam int unsigned NONCE_BITS    = 32;
  localparam int unsigned BLOCK_BITS    = 512;
  localparam int unsigned LEN_BITS      = 64;

  // Bit offsets into block2, index 0 = first transmitted bit
  localparam int unsigned TAIL_OFS  = 0;
  localparam int unsigned NONCE_OFS = 96;
  localparam int unsigned PAD_OFS   = 128;
  localparam int unsigned LEN_OFS   = 448;
  localparam int unsigned PAD_BITS  = LEN_OFS - PAD_OFS;

  // SHA-256 padding between message end and length field: a single 1 then zeros
  localparam logic [0:PAD_BITS-1] SHA_PAD = {1'b1, {(PAD_BITS-1){1'b0}}};

  typedef struct packed {
    logic [0:MIDSTATE_BITS-1] midstate;
    logic [0:TAIL_BITS-1]     tail;
    logic [NONCE_BITS-1:0]    nonce_start;
    logic [NONCE_BITS-1:0]    nonce_end;
  } job_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } feeder_state_e;

  function automatic logic [NONCE_BITS-1:0] bswap32(input logic [NONCE_BITS-1:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/nonce_block_feeder_if.sv
// Job intake and block2 issue handshake between host, feeder and hash core.
interface nonce_block_feeder_if;
  import miner_pkg::*;

  logic                     job_valid;
  logic                     job_ready;
  logic [0:MIDSTATE_BITS-1] job_midstate;
  logic [0:TAIL_BITS-1]     job_tail;
  logic [NONCE_BITS-1:0]    job_nonce_start;
  logic [NONCE_BITS-1:0]    job_nonce_end;

  logic [0:MIDSTATE_BITS-1] midstate;
  logic [0:BLOCK_BITS-1]    block2;
  logic                     blk_valid;
  logic                     blk_ready;
  logic [NONCE_BITS-1:0]    blk_nonce;

  // Feeder side
  modport slave (
    input  job_valid, job_midstate, job_tail, job_nonce_start, job_nonce_end,
    output job_ready,
    output midstate, block2, blk_valid, blk_nonce,
    input  blk_ready
  );

  // Host / hash-core side
  modport master (
    output job_valid, job_midstate, job_tail, job_nonce_start, job_nonce_end,
    input  job_ready,
    input  midstate, block2, blk_valid, blk_nonce,
    output blk_ready
  );

endinterface

// File: rtl/nonce_block_feeder_block2_pack.sv
// Combinational assembly of the padded second SHA-256 block.
// NONCE_BSWAP_EN: place the nonce byte-reversed (Bitcoin little-endian serialization).
module block2_pack
  import miner_pkg::*;
#(
  parameter int unsigned MSG_LEN_BITS = 640
) (
  input  logic [0:TAIL_BITS-1]  i_tail,
  input  logic [NONCE_BITS-1:0] i_nonce,
  output logic [0:BLOCK_BITS-1] o_block2
);

  logic [NONCE_BITS-1:0] w_nonce_field;
  logic [LEN_BITS-1:0]   w_len;

`ifdef NONCE_BSWAP_EN
  assign w_nonce_field = bswap32(i_nonce);
`else
  assign w_nonce_field = i_nonce;
`endif

  assign w_len    = LEN_BITS'(MSG_LEN_BITS);
  assign o_block2 = {i_tail, w_nonce_field, SHA_PAD, w_len};

endmodule

// File: rtl/nonce_block_feeder.sv
// Walks a job's nonce range and presents midstate + padded block2 to the hash core.
// Build option: NONCE_BSWAP_EN (byte-reversed nonce field inside block2).
module nonce_block_feeder
  import miner_pkg::*;
#(
  parameter int unsigned NONCE_STEP   = 1,
  parameter int unsigned MSG_LEN_BITS = 640
) (
  input  logic                   clk,
  input  logic                   rst,
  nonce_block_feeder_if.slave    bus,
  input  logic                   found,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   exhausted,
  output logic [NONCE_BITS-1:0]  issued_count
);

  feeder_state_e r_state;
  feeder_state_e w_state_nxt;

  logic [0:MIDSTATE_BITS-1] r_midstate;
  logic [0:TAIL_BITS-1]     r_tail;
  logic [NONCE_BITS-1:0]    r_nonce_end;
  logic [NONCE_BITS-1:0]    r_nonce;
  logic [NONCE_BITS-1:0]    r_issued;
  logic                     r_exhausted;
  logic                     r_loaded;

  job_t                     w_job;
  logic                     w_take_job;
  logic                     w_fire;
  logic                     w_stop;
  logic                     w_last;
  logic [0:BLOCK_BITS-1]    w_block2;

  assign w_job = '{
    midstate:    bus.job_midstate,
    tail:        bus.job_tail,
    nonce_start: bus.job_nonce_start,
    nonce_end:   bus.job_nonce_end
  };

  assign w_take_job = (r_state == IDLE) && bus.job_valid;
  assign w_fire     = (r_state == ISSUE) && bus.blk_ready;
  assign w_stop     = (r_state == ISSUE) && (found || abort);
  // Modular distance to the end keeps wrapped ranges (end < start) correct
  assign w_last     = (r_nonce_end - r_nonce) < NONCE_BITS'(NONCE_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_take_job) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (w_stop || (w_fire && w_last)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_midstate  <= '0;
      r_tail      <= '0;
      r_nonce_end <= '0;
      r_nonce     <= '0;
      r_issued    <= '0;
      r_exhausted <= 1'b0;
      r_loaded    <= 1'b0;
    end else begin
      if (w_take_job) begin
        r_midstate  <= w_job.midstate;
        r_tail      <= w_job.tail;
        r_nonce_end <= w_job.nonce_end;
        r_nonce     <= w_job.nonce_start;
        r_issued    <= '0;
        r_exhausted <= 1'b0;
        r_loaded    <= 1'b1;
      end
      // A block taken in the same cycle as found/abort still counts
      if (w_fire) begin
        r_issued <= r_issued + 1'b1;
      end
      if (w_fire && !w_stop) begin
        if (w_last) begin
          r_exhausted <= 1'b1;
        end else begin
          r_nonce <= r_nonce + NONCE_BITS'(NONCE_STEP);
        end
      end
    end
  end

  block2_pack #(
    .MSG_LEN_BITS(MSG_LEN_BITS)
  ) u_pack (
    .i_tail   (r_tail),
    .i_nonce  (r_nonce),
    .o_block2 (w_block2)
  );

  // block2 reads zero until a job has been latched so reset leaves every output clear
  assign bus.block2    = r_loaded ? w_block2 : '0;
  assign bus.midstate  = r_midstate;
  assign bus.blk_nonce = r_nonce;
  assign bus.blk_valid = (r_state == ISSUE);
  assign bus.job_ready = (r_state == IDLE) && !rst;

  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);
  assign exhausted    = r_exhausted;
  assign issued_count = r_issued;

endmodule

// File: tb/tb_nonce_block_feeder.sv
// Directed self-checking bench for nonce_block_feeder (default or NONCE_BSWAP_EN build).
module tb_nonce_block_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        found = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        exhausted;
  logic [31:0] issued_count;

  int n_total = 0;
  int n_bad   = 0;

  logic [0:255] mid_v;
  logic [0:95]  tail_v;
  logic [0:511] saved_blk;

  nonce_block_feeder_if u_if ();

  nonce_block_feeder #(
    .NONCE_STEP   (1),
    .MSG_LEN_BITS (640)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (u_if),
    .found        (found),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .exhausted    (exhausted),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] nfield(input logic [31:0] n);
`ifdef NONCE_BSWAP_EN
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
`else
    return n;
`endif
  endfunction

  task automatic check_blk(input string tag, input logic [31:0] n);
    chk({tag, "_valid"}, 64'(u_if.blk_valid), 64'd1);
    chk({tag, "_nonce"}, 64'(u_if.blk_nonce), 64'(n));
    chk({tag, "_field"}, 64'(u_if.block2[96:127]), 64'(nfield(n)));
    chk({tag, "_len"},   64'(u_if.block2[448:511]), 64'h280);
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] e);
    u_if.job_midstate    = mid_v;
    u_if.job_tail        = tail_v;
    u_if.job_nonce_start = s;
    u_if.job_nonce_end   = e;
    u_if.job_valid       = 1'b1;
    tick();
    u_if.job_valid       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_n;
    logic        stalled;
    logic        seen_done;
    logic [15:0] pat;
    logic [31:0] wexp [4];

    mid_v  = {4{64'h0123456789ABCDEF}};
    tail_v = 96'hA1B2C3D4_E5F60718_293A4B5C;
    pat    = 16'b1011_0010_0110_1101;
    wexp   = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

    u_if.job_valid       = 1'b0;
    u_if.job_midstate    = '0;
    u_if.job_tail        = '0;
    u_if.job_nonce_start = '0;
    u_if.job_nonce_end   = '0;
    u_if.blk_ready       = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_job_ready", 64'(u_if.job_ready), 64'd0);
    chk("rst_blk_valid", 64'(u_if.blk_valid), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_done",      64'(done), 64'd0);
    chk("rst_exh",       64'(exhausted), 64'd0);
    chk("rst_count",     64'(issued_count), 64'd0);
    chk("rst_block2",    64'(|u_if.block2), 64'd0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("idle_job_ready", 64'(u_if.job_ready), 64'd1);

    // Basic range 0..3, core always ready
    u_if.blk_ready = 1'b1;
    launch(32'd0, 32'd3);
    chk("b_tail_hi", 64'(u_if.block2[0:63]), 64'hA1B2C3D4E5F60718);
    chk("b_tail_lo", 64'(u_if.block2[64:95]), 64'h293A4B5C);
    chk("b_pad1",    64'(u_if.block2[128]), 64'd1);
    chk("b_pad0",    64'(|u_if.block2[129:447]), 64'd0);
    chk("b_mid",     64'(u_if.midstate[0:63]), 64'h0123456789ABCDEF);
    for (int i = 0; i < 4; i++) begin
      check_blk("basic", 32'(i));
      tick();
    end
    chk("basic_done",  64'(done), 64'd1);
    chk("basic_valid", 64'(u_if.blk_valid), 64'd0);
    chk("basic_count", 64'(issued_count), 64'd4);
    chk("basic_exh",   64'(exhausted), 64'd1);
    tick();
    chk("basic_pulse", 64'(done), 64'd0);
    chk("basic_idle",  64'(u_if.job_ready), 64'd1);

    // Backpressure, range 10..14
    u_if.blk_ready = 1'b0;
    launch(32'd10, 32'd14);
    exp_n     = 32'd10;
    stalled   = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (u_if.blk_valid) begin
        chk("bp_nonce", 64'(u_if.blk_nonce), 64'(exp_n));
        if (stalled) chk("bp_hold", 64'(u_if.block2 == saved_blk), 64'd1);
        u_if.blk_ready = pat[c % 16];
        if (u_if.blk_ready) begin
          exp_n   = exp_n + 1;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          saved_blk = u_if.block2;
        end
      end
      tick();
    end
    chk("bp_done",  64'(seen_done), 64'd1);
    chk("bp_next",  64'(exp_n), 64'd15);
    chk("bp_count", 64'(issued_count), 64'd5);
    chk("bp_exh",   64'(exhausted), 64'd1);
    u_if.blk_ready = 1'b1;
    tick();

    // Wrap across 2^32
    launch(32'hFFFFFFFE, 32'h00000001);
    for (int i = 0; i < 4; i++) begin
      check_blk("wrap", wexp[i]);
      tick();
    end
    chk("wrap_done",  64'(done), 64'd1);
    chk("wrap_count", 64'(issued_count), 64'd4);
    chk("wrap_exh",   64'(exhausted), 64'd1);
    tick();

    // Early stop on found with the 3rd acceptance; a job offered mid-run is ignored
    launch(32'd0, 32'd100);
    check_blk("es0", 32'd0);
    tick();
    check_blk("es1", 32'd1);
    u_if.job_valid       = 1'b1;
    u_if.job_nonce_start = 32'd77;
    u_if.job_midstate    = ~mid_v;
    tick();
    u_if.job_valid    = 1'b0;
    u_if.job_midstate = mid_v;
    check_blk("es2", 32'd2);
    chk("es_mid_kept", 64'(u_if.midstate[0:63]), 64'h0123456789ABCDEF);
    found = 1'b1;
    tick();
    found = 1'b0;
    chk("es_valid", 64'(u_if.blk_valid), 64'd0);
    chk("es_done",  64'(done), 64'd1);
    chk("es_count", 64'(issued_count), 64'd3);
    chk("es_exh",   64'(exhausted), 64'd0);
    tick();
    found = 1'b1;
    tick();
    found = 1'b0;
    chk("idle_found_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a job
    launch(32'd0, 32'd100);
    tick();
    tick();
    u_if.blk_ready = 1'b0;
    chk("mr_pre_count", 64'(issued_count), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("mr_valid",  64'(u_if.blk_valid), 64'd0);
    chk("mr_busy",   64'(busy), 64'd0);
    chk("mr_count",  64'(issued_count), 64'd0);
    chk("mr_nonce",  64'(u_if.blk_nonce), 64'd0);
    chk("mr_mid",    64'(|u_if.midstate), 64'd0);
    chk("mr_block2", 64'(|u_if.block2), 64'd0);
    chk("mr_ready",  64'(u_if.job_ready), 64'd0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("mr_ready_rel", 64'(u_if.job_ready), 64'd1);
    u_if.blk_ready = 1'b1;
    launch(32'd5, 32'd6);
    check_blk("mr5", 32'd5);
    tick();
    check_blk("mr6", 32'd6);
    tick();
    chk("mr_done",  64'(done), 64'd1);
    chk("mr_count2", 64'(issued_count), 64'd2);
    tick();

    // Byte order, single-nonce range (start == end)
    launch(32'h11223344, 32'h11223344);
    chk("bo_nonce", 64'(u_if.blk_nonce), 64'h11223344);
`ifdef NONCE_BSWAP_EN
    chk("bo_field", 64'(u_if.block2[96:127]), 64'h44332211);
`else
    chk("bo_field", 64'(u_if.block2[96:127]), 64'h11223344);
`endif
    tick();
    chk("one_done",  64'(done), 64'd1);
    chk("one_count", 64'(issued_count), 64'd1);
    chk("one_exh",   64'(exhausted), 64'd1);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
